// File: rtl/hazard_interlock.sv
// Load-use / branch-in-ID interlock and control/exception flush controller for the
// 5-stage pipeline, with stall and flush performance counters.
module hazard_interlock #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_Branch,
  input  logic             ID_Jr,
  input  logic             ID_Taken,
  input  logic             EX_RegWr,
  input  logic [1:0]       EX_MemToReg,
  input  logic [1:0]       EX_RegDst,
  input  logic [4:0]       EX_Rd,
  input  logic [4:0]       EX_Rt,
  input  logic             MEM_RegWr,
  input  logic [1:0]       MEM_MemToReg,
  input  logic [1:0]       MEM_RegDst,
  input  logic [4:0]       MEM_Rd,
  input  logic [4:0]       MEM_Rt,
  input  logic             Exc_Req,
  output logic             PC_Wr,
  output logic             IF_ID_Wr,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt
);

  // StHold always carries one remaining stall cycle, so no separate counter is kept.
  typedef enum logic [0:0] {StRun, StHold} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic [4:0] ex_dst, mem_dst;
  logic       use_rs, ctrl_use;
  logic       ex_hit, mem_hit;
  logic [1:0] n_ex, n_mem, n_stall;
  logic       stall;
  logic       flush_evt;

  function automatic logic [4:0] dest_reg(input logic [1:0] dst, input logic [4:0] rd,
                                          input logic [4:0] rt);
    logic [4:0] r;
    case (dst)
      2'd0:    r = rd;
      2'd1:    r = rt;
      2'd2:    r = 5'd31;
      default: r = 5'd26;
    endcase
    return r;
  endfunction

  assign ex_dst   = dest_reg(EX_RegDst, EX_Rd, EX_Rt);
  assign mem_dst  = dest_reg(MEM_RegDst, MEM_Rd, MEM_Rt);
  assign use_rs   = ID_UseRs | ID_Jr;
  assign ctrl_use = ID_Branch | ID_Jr;

  assign ex_hit  = EX_RegWr && (ex_dst != 5'd0) &&
                   ((use_rs && (ex_dst == ID_Rs)) || (ID_UseRt && (ex_dst == ID_Rt)));
  assign mem_hit = MEM_RegWr && (mem_dst != 5'd0) &&
                   ((use_rs && (mem_dst == ID_Rs)) || (ID_UseRt && (mem_dst == ID_Rt)));

  // Required bubbles: ID-resolved control needs its operand a stage earlier than the ALU.
  always_comb begin
    n_ex  = 2'd0;
    n_mem = 2'd0;
    if (ex_hit) begin
      if (ctrl_use) begin
        case (EX_MemToReg)
          2'd0:    n_ex = 2'd1;
          2'd1:    n_ex = 2'd2;
          default: n_ex = 2'd0;
        endcase
      end else if (EX_MemToReg == 2'd1) begin
        n_ex = 2'd1;
      end
    end
    if (mem_hit && ctrl_use && (MEM_MemToReg == 2'd1)) begin
      n_mem = 2'd1;
    end
    n_stall = (n_ex > n_mem) ? n_ex : n_mem;
  end

  assign stall = (state_q == StHold) || (n_stall != 2'd0);

  always_comb begin
    state_d     = StRun;
    PC_Wr       = 1'b1;
    IF_ID_Wr    = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    flush_evt   = 1'b0;
    if (!reset) begin
      state_d = StRun;
    end else if (Exc_Req) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      flush_evt   = 1'b1;
    end else if (stall) begin
      PC_Wr       = 1'b0;
      IF_ID_Wr    = 1'b0;
      ID_EX_Flush = 1'b1;
      if ((state_q == StRun) && (n_stall == 2'd2)) begin
        state_d = StHold;
      end
    end else if (ID_Taken) begin
      // Taken transfer squashes the delay-slot fetch.
      IF_ID_Flush = 1'b1;
      flush_evt   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (!PC_Wr) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_evt) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign Stall_Cnt = stall_cnt_q;
  assign Flush_Cnt = flush_cnt_q;

endmodule
